// File: rtl/nbit_reg_pkg.sv
// nbit_reg_pkg: FunSel encoding shared by the register file and its cells.
// Rev 1.0
`default_nettype none

package nbit_reg_pkg;

    localparam int FS_W = 3;

    localparam logic [FS_W-1:0] FS_CLR  = 3'b000;
    localparam logic [FS_W-1:0] FS_LOAD = 3'b001;
    localparam logic [FS_W-1:0] FS_DEC  = 3'b010;
    localparam logic [FS_W-1:0] FS_INC  = 3'b011;
    localparam logic [FS_W-1:0] FS_SHL  = 3'b100;
    localparam logic [FS_W-1:0] FS_SHR  = 3'b101;
    localparam logic [FS_W-1:0] FS_ROL  = 3'b110;
    localparam logic [FS_W-1:0] FS_HOLD = 3'b111;

endpackage

`default_nettype wire

// File: rtl/nbit_reg_cell.sv
// nbit_reg_cell: one W-bit register with its sticky wrap flag.
// Rev 1.0
`default_nettype none

module nbit_reg_cell
    import nbit_reg_pkg::*;
#(
    parameter int W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [FS_W-1:0] FunSel,
    input  logic [W-1:0]    I,
    output logic [W-1:0]    Q,
    output logic            Wrap
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Q    <= '0;
            Wrap <= 1'b0;
        end else if (en) begin
            case (FunSel)
                FS_CLR: begin
                    Q    <= '0;
                    Wrap <= 1'b0;
                end
                FS_LOAD: begin
                    Q    <= I;
                    Wrap <= 1'b0;
                end
                FS_DEC: begin
                    Q <= Q - W'(1);
                    if (Q == '0) Wrap <= 1'b1;
                end
                FS_INC: begin
                    Q <= Q + W'(1);
                    if (&Q) Wrap <= 1'b1;
                end
                // Bits shifted out accumulate into the sticky flag.
                FS_SHL: begin
                    Q    <= {Q[W-2:0], 1'b0};
                    Wrap <= Wrap | Q[W-1];
                end
                FS_SHR: begin
                    Q    <= {1'b0, Q[W-1:1]};
                    Wrap <= Wrap | Q[0];
                end
                FS_ROL: begin
                    Q <= {Q[W-2:0], Q[W-1]};
                end
                default: begin
                    Q    <= Q;
                    Wrap <= Wrap;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/nbit_reg_file.sv
// nbit_reg_file: NREG x W register bank with masked writes and two read ports.
// Rev 1.0
`default_nettype none

module nbit_reg_file
    import nbit_reg_pkg::*;
#(
    parameter  int W     = 8,
    parameter  int NREG  = 4,
    localparam int SEL_W = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            E,
    input  logic [NREG-1:0] RegSel,
    input  logic [FS_W-1:0] FunSel,
    input  logic [W-1:0]    I,
    input  logic [SEL_W-1:0] OutASel,
    input  logic [SEL_W-1:0] OutBSel,
    output logic [W-1:0]    OutA,
    output logic [W-1:0]    OutB,
    output logic [NREG-1:0] Wrap
);

    logic [W-1:0] q [NREG];

    for (genvar k = 0; k < NREG; k++) begin : g_cell
        nbit_reg_cell #(
            .W (W)
        ) u_cell (
            .clk    (clk),
            .rst_n  (rst_n),
            .en     (E & RegSel[k]),
            .FunSel (FunSel),
            .I      (I),
            .Q      (q[k]),
            .Wrap   (Wrap[k])
        );
    end

    // Select codes with no matching register fall through to zero.
    always_comb begin
        OutA = '0;
        OutB = '0;
        for (int k = 0; k < NREG; k++) begin
            if (OutASel == SEL_W'(k)) OutA = q[k];
            if (OutBSel == SEL_W'(k)) OutB = q[k];
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_nbit_reg_file.sv
// tb_nbit_reg_file: directed self-checking bench for nbit_reg_file (W=8, NREG=4 and NREG=3).
// Rev 1.0
`default_nettype none

module tb_nbit_reg_file;

    localparam logic [2:0] CLR = 3'b000, LOAD = 3'b001, DEC = 3'b010, INC = 3'b011;
    localparam logic [2:0] SHL = 3'b100, SHR = 3'b101, ROL = 3'b110, HOLD = 3'b111;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       E = 1'b0;
    logic [3:0] RegSel = '0;
    logic [2:0] FunSel = '0;
    logic [7:0] I = '0;
    logic [1:0] OutASel = '0, OutBSel = '0;
    logic [7:0] OutA, OutB;
    logic [3:0] Wrap;

    logic [1:0] a_sel3 = '0, b_sel3 = '0;
    logic [7:0] a3, b3;
    logic [2:0] wrap3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    nbit_reg_file #(.W(8), .NREG(4)) dut (
        .clk(clk), .rst_n(rst_n), .E(E), .RegSel(RegSel), .FunSel(FunSel), .I(I),
        .OutASel(OutASel), .OutBSel(OutBSel), .OutA(OutA), .OutB(OutB), .Wrap(Wrap)
    );

    nbit_reg_file #(.W(8), .NREG(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .E(E), .RegSel(RegSel[2:0]), .FunSel(FunSel), .I(I),
        .OutASel(a_sel3), .OutBSel(b_sel3), .OutA(a3), .OutB(b3), .Wrap(wrap3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] sel, input logic [2:0] fs, input logic [7:0] d);
        E = 1'b1; RegSel = sel; FunSel = fs; I = d;
        step();
        E = 1'b0; RegSel = '0; FunSel = HOLD;
    endtask

    task automatic rd(input int k, output logic [7:0] v);
        OutASel = 2'(k);
        #1;
        v = OutA;
    endtask

    task automatic test_reset();
        logic [7:0] v;
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
        wr(4'b0010, LOAD, 8'h77);
        OutASel = 2'd1; OutBSel = 2'd1;
        #3 rst_n = 1'b0;
        #1;
        total++;
        if (OutA !== 8'h00 || OutB !== 8'h00) begin
            bad++; $display("FAIL async_reset_out: OutA=%h OutB=%h expected 00", OutA, OutB);
        end
        total++;
        if (Wrap !== 4'b0000) begin
            bad++; $display("FAIL async_reset_wrap: got %b expected 0000", Wrap);
        end
        step();
        rst_n = 1'b1;
        step();
        wr(4'b0010, LOAD, 8'hA5);
        for (int k = 0; k < 4; k++) begin
            rd(k, v);
            total++;
            if (v !== ((k == 1) ? 8'hA5 : 8'h00)) begin
                bad++; $display("FAIL load_r%0d: got %h expected %h", k, v, (k == 1) ? 8'hA5 : 8'h00);
            end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] v;
        logic [7:0] exp_v [5] = '{8'hFF, 8'h00, 8'h01, 8'h00, 8'hFF};
        logic       exp_w [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [2:0] ops   [5] = '{LOAD, INC, INC, CLR, DEC};
        for (int n = 0; n < 5; n++) begin
            wr(4'b0001, ops[n], 8'hFF);
            rd(0, v);
            total++;
            if (v !== exp_v[n] || Wrap[0] !== exp_w[n]) begin
                bad++; $display("FAIL wrap_step%0d: R0=%h Wrap0=%b expected %h/%b", n, v, Wrap[0], exp_v[n], exp_w[n]);
            end
        end
    endtask

    task automatic test_multi();
        logic [7:0] v;
        wr(4'b1111, CLR, 8'h00);
        wr(4'b1111, INC, 8'h00);
        for (int n = 0; n < 4; n++) begin
            if (n == 1) begin
                E = 1'b0; RegSel = 4'b1111; FunSel = INC; step();
            end else if (n == 2) begin
                E = 1'b1; RegSel = 4'b0000; FunSel = INC; step();
            end else if (n == 3) begin
                E = 1'b1; RegSel = 4'b1111; FunSel = HOLD; step();
            end
            E = 1'b0; RegSel = '0;
            for (int k = 0; k < 4; k++) begin
                rd(k, v);
                total++;
                if (v !== 8'h01) begin
                    bad++; $display("FAIL multi_case%0d_r%0d: got %h expected 01", n, k, v);
                end
            end
        end
        total++;
        if (Wrap !== 4'b0000) begin
            bad++; $display("FAIL multi_wrap: got %b expected 0000", Wrap);
        end
    endtask

    task automatic test_shift();
        logic [7:0] v;
        wr(4'b0100, LOAD, 8'b1000_0001);
        wr(4'b0100, SHL, 8'h00);
        rd(2, v);
        total++;
        if (v !== 8'b0000_0010 || Wrap[2] !== 1'b1) begin
            bad++; $display("FAIL shl: R2=%b Wrap2=%b expected 00000010/1", v, Wrap[2]);
        end
        wr(4'b0100, LOAD, 8'b1000_0001);
        wr(4'b0100, ROL, 8'h00);
        rd(2, v);
        total++;
        if (v !== 8'b0000_0011 || Wrap[2] !== 1'b0) begin
            bad++; $display("FAIL rol: R2=%b Wrap2=%b expected 00000011/0", v, Wrap[2]);
        end
        wr(4'b0100, SHR, 8'h00);
        rd(2, v);
        total++;
        if (v !== 8'b0000_0001 || Wrap !== 4'b0100) begin
            bad++; $display("FAIL shr: R2=%b Wrap=%b expected 00000001/0100", v, Wrap);
        end
    endtask

    task automatic test_read_during_write();
        wr(4'b1000, LOAD, 8'h10);
        OutASel = 2'd3; OutBSel = 2'd3;
        E = 1'b1; RegSel = 4'b1000; FunSel = INC;
        #1;
        total++;
        if (OutA !== 8'h10 || OutB !== 8'h10) begin
            bad++; $display("FAIL rdw_before: OutA=%h OutB=%h expected 10", OutA, OutB);
        end
        step();
        E = 1'b0; RegSel = '0;
        total++;
        if (OutA !== 8'h11 || OutB !== 8'h11) begin
            bad++; $display("FAIL rdw_after: OutA=%h OutB=%h expected 11", OutA, OutB);
        end
    endtask

    task automatic test_out_of_range();
        wr(4'b0111, LOAD, 8'h42);
        a_sel3 = 2'd2; b_sel3 = 2'd3;
        #1;
        total++;
        if (a3 !== 8'h42 || b3 !== 8'h00) begin
            bad++; $display("FAIL nreg3_sel: A(2)=%h B(3)=%h expected 42/00", a3, b3);
        end
        a_sel3 = 2'b11;
        #1;
        total++;
        if (a3 !== 8'h00) begin
            bad++; $display("FAIL nreg3_oor: OutA=%h expected 00", a3);
        end
    endtask

    task automatic test_reset_mid_write();
        logic [7:0] v;
        OutASel = 2'd1;
        E = 1'b1; RegSel = 4'b0010; FunSel = LOAD; I = 8'h5A;
        #3 rst_n = 1'b0;
        step();
        total++;
        if (OutA !== 8'h00 || Wrap !== 4'b0000) begin
            bad++; $display("FAIL rst_mid_write: R1=%h Wrap=%b expected 00/0000", OutA, Wrap);
        end
        rst_n = 1'b1; E = 1'b0; RegSel = '0;
        step();
        rd(1, v);
        total++;
        if (v !== 8'h00 || Wrap !== 4'b0000) begin
            bad++; $display("FAIL rst_release: R1=%h Wrap=%b expected 00/0000", v, Wrap);
        end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_multi();
        test_shift();
        test_read_during_write();
        test_out_of_range();
        test_reset_mid_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
